// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// Elastic register chain of DEPTH stages with a per-stage valid bit and a
// valid/ready handshake at both ends. A global freeze stalls every stage and
// a global flush squashes every stage, so hazard and branch logic do not need
// per-stage wiring.
module pipe_stage_chain #(
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH      = 3,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0,
  localparam int                OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  stage_vld;
  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]  take;
  logic              take_last;
  logic              in_xfer;
  logic              out_xfer;

  // The last stage drains only when downstream accepts and the chain is not
  // stalled or being squashed.
  assign take_last = out_ready & ~freeze & ~flush;

  // Stage i may hand its payload forward when any later stage holds a bubble,
  // or when the whole tail is full but the last stage is draining. Built
  // from an accumulated bubble flag so no signal feeds back into itself.
  always_comb begin
    logic bubble;
    bubble          = 1'b0;
    take            = '0;
    take[DEPTH-1]   = take_last;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      bubble  = bubble | ~stage_vld[i+1];
      take[i] = bubble | take_last;
    end
  end

  // in_ready is held low while reset is asserted so nothing is accepted
  // before the chain is live; out_valid is masked while stalled or squashed.
  assign in_ready  = rst & ~freeze & ~flush & (~stage_vld[0] | take[0]);
  assign out_valid = stage_vld[DEPTH-1] & ~freeze & ~flush;
  assign out_data  = stage_data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Stage registers: reset and flush clear every stage to RESET_DATA, freeze
  // holds everything, otherwise payloads advance. Data registers only load
  // when a valid payload moves in, so a stage that empties keeps stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= RESET_DATA;
      end
    end else if (flush) begin
      stage_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= RESET_DATA;
      end
    end else if (!freeze) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (take[i-1]) begin
          stage_vld[i] <= stage_vld[i-1];
          if (stage_vld[i-1]) begin
            stage_data[i] <= stage_data[i-1];
          end
        end
      end
      if (in_ready) begin
        stage_vld[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= in_data;
        end
      end
    end
  end

  // Occupancy tracks transfers at the two ends, which keeps it equal to the
  // number of set valid bits without a popcount tree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

endmodule
